// File: rtl/pq_rr_arbiter.sv
// Round-robin arbiter sharing one priority queue among N_REQ requesters.
// Issues one PQ op per cycle at most and returns a per-requester response when the PQ is done.
module pq_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int KV_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      op,
  input  logic [KV_W*N_REQ-1:0]   kv_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [KV_W-1:0]         rsp_kv,
  output logic                    rsp_err,
  output logic                    pq_enq,
  output logic                    pq_deq,
  output logic [KV_W-1:0]         pq_kvi,
  input  logic [KV_W-1:0]         pq_kvo,
  input  logic                    pq_full,
  input  logic                    pq_empty,
  input  logic                    pq_busy,
  output logic [CNT_W-1:0]        ops_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;

  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [N_REQ-1:0] owner;
  logic             rej_q;
  logic [KV_W-1:0]  kv_q;
  logic             err_q;

  logic [N_REQ-1:0] active;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [1:0]       win_op;
  logic             can_issue;
  logic             issue;
  logic             complete;
  logic [KV_W-1:0]  nxt_kv;
  logic             nxt_err;
  logic             nxt_rej;
  int               idx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      active[i] = req[i] && (op[2*i +: 2] != 2'b00);
    end
  end

  // Scan requesters starting at ptr with wraparound; first active one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && active[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign win_op = op[{win, 1'b0} +: 2];

  // A rejected op never started the PQ, so it completes without waiting on pq_busy.
  assign complete  = !rst && (state == ST_PEND) && (!pq_busy || rej_q);
  assign can_issue = !rst && ((state == ST_ARB) || !pq_busy);
  assign issue     = can_issue && found;

  assign rsp_valid = complete ? owner : '0;
  assign rsp_kv    = kv_q;
  assign rsp_err   = err_q;

  always_comb begin
    gnt     = '0;
    pq_enq  = 1'b0;
    pq_deq  = 1'b0;
    pq_kvi  = '0;
    nxt_kv  = '0;
    nxt_err = 1'b0;
    nxt_rej = 1'b0;
    if (issue) begin
      gnt[win] = 1'b1;
      pq_kvi   = kv_in[win*KV_W +: KV_W];
      case (win_op)
        OP_ENQ: begin
          if (pq_full) begin
            nxt_err = 1'b1;
            nxt_rej = 1'b1;
          end else begin
            pq_enq = 1'b1;
          end
        end
        OP_DEQ: begin
          if (pq_empty) begin
            nxt_err = 1'b1;
            nxt_rej = 1'b1;
          end else begin
            pq_deq = 1'b1;
            nxt_kv = pq_kvo;
          end
        end
        OP_REP: begin
          // Replace on an empty queue degrades to a plain enqueue but reports no data.
          pq_enq = 1'b1;
          if (pq_empty) begin
            nxt_err = 1'b1;
          end else begin
            pq_deq = 1'b1;
            nxt_kv = pq_kvo;
          end
        end
        default: begin
          nxt_err = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ARB;
      ptr     <= '0;
      owner   <= '0;
      rej_q   <= 1'b0;
      kv_q    <= '0;
      err_q   <= 1'b0;
      ops_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (issue) begin
        state <= ST_PEND;
        ptr   <= (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
        owner <= gnt;
        rej_q <= nxt_rej;
        kv_q  <= nxt_kv;
        err_q <= nxt_err;
      end else if (complete) begin
        state <= ST_ARB;
        rej_q <= 1'b0;
      end
      if (complete) begin
        if (err_q) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
          if (ops_cnt != '1) ops_cnt <= ops_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pq_rr_arbiter.sv
// Directed bench for pq_rr_arbiter with a small sorted-queue PQ model (min key at head).
module tb_pq_rr_arbiter;
  localparam int N   = 4;
  localparam int KW  = 32;
  localparam int CW  = 16;
  localparam int CAP = 4;

  localparam logic [1:0] ENQ = 2'b01;
  localparam logic [1:0] DEQ = 2'b10;
  localparam logic [1:0] REP = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [2*N-1:0] op;
  logic [KW*N-1:0] kv_in;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [KW-1:0] rsp_kv;
  logic          rsp_err;
  logic          pq_enq;
  logic          pq_deq;
  logic [KW-1:0] pq_kvi;
  logic [KW-1:0] pq_kvo   = '0;
  logic          pq_full  = 1'b0;
  logic          pq_empty = 1'b1;
  logic          pq_busy  = 1'b0;
  logic [CW-1:0] ops_cnt;
  logic [CW-1:0] err_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pq_rr_arbiter #(.N_REQ(N), .KV_W(KW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .kv_in(kv_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
    .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
    .ops_cnt(ops_cnt), .err_cnt(err_cnt)
  );

  // PQ model: dequeue before enqueue so a replace on a full queue works; busy for busy_len cycles per op.
  int unsigned pq_q[$];
  int busy_len = 0;
  int busy_cnt = 0;
  int pos;

  always @(posedge clk) begin
    if (rst) begin
      pq_q.delete();
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (pq_deq && pq_q.size() > 0) void'(pq_q.pop_front());
      if (pq_enq && pq_q.size() < CAP) begin
        pos = 0;
        while (pos < pq_q.size() && pq_q[pos] <= pq_kvi) pos++;
        pq_q.insert(pos, pq_kvi);
      end
      if (pq_enq || pq_deq) busy_cnt = busy_len;
    end
    pq_busy  <= (busy_cnt != 0);
    pq_empty <= (pq_q.size() == 0);
    pq_full  <= (pq_q.size() == CAP);
    pq_kvo   <= (pq_q.size() > 0) ? pq_q[0] : '0;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] r, input logic [1:0] o, input logic [31:0] base);
    req = r;
    for (int i = 0; i < N; i++) begin
      op[2*i +: 2]    = o;
      kv_in[KW*i +: KW] = base + 32'(i);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    apply_stimulus('0, ENQ, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  // One op on a 1-cycle PQ: issue cycle then completion cycle; leaves time just after the next edge.
  task automatic do_op(input int r, input logic [1:0] o, input logic [31:0] base,
                       input logic exp_enq, input logic exp_deq,
                       input logic [31:0] exp_kv, input logic exp_err, input logic chk_kv);
    apply_stimulus(N'(1 << r), o, base);
    @(negedge clk);
    check_output("op_gnt", 32'(gnt), 32'(1 << r));
    check_output("op_pq_enq", 32'(pq_enq), 32'(exp_enq));
    check_output("op_pq_deq", 32'(pq_deq), 32'(exp_deq));
    check_output("op_pq_kvi", pq_kvi, base + 32'(r));
    next_cycle();
    apply_stimulus('0, ENQ, 0);
    @(negedge clk);
    check_output("op_rsp_valid", 32'(rsp_valid), 32'(1 << r));
    check_output("op_rsp_err", 32'(rsp_err), 32'(exp_err));
    if (chk_kv) check_output("op_rsp_kv", rsp_kv, exp_kv);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    apply_stimulus(4'b1111, ENQ, 40);

    // Reset held two cycles with all requests up
    @(posedge clk);
    @(negedge clk);
    check_output("rst_gnt", 32'(gnt), 32'h0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("rst_pq_enq", 32'(pq_enq), 32'h0);
    check_output("rst_pq_deq", 32'(pq_deq), 32'h0);
    check_output("rst_ops_cnt", 32'(ops_cnt), 32'h0);
    check_output("rst_err_cnt", 32'(err_cnt), 32'h0);
    next_cycle();
    rst = 1'b0;

    // Fairness: rotating grants, fifth ENQ hits a full PQ
    @(negedge clk);
    check_output("fair_gnt_c1", 32'(gnt), 32'h1);
    check_output("fair_enq_c1", 32'(pq_enq), 32'h1);
    check_output("fair_kvi_c1", pq_kvi, 32'd40);
    for (int c = 2; c <= 5; c++) begin
      next_cycle();
      @(negedge clk);
      check_output("fair_gnt", 32'(gnt), 32'(1 << ((c - 1) % 4)));
      check_output("fair_rsp", 32'(rsp_valid), 32'(1 << ((c - 2) % 4)));
      check_output("fair_kvi", pq_kvi, 32'd40 + 32'((c - 1) % 4));
      check_output("fair_enq", 32'(pq_enq), (c < 5) ? 32'h1 : 32'h0);
    end
    next_cycle();
    apply_stimulus('0, ENQ, 0);
    @(negedge clk);
    check_output("fair_gnt_c6", 32'(gnt), 32'h0);
    check_output("fair_rsp_c6", 32'(rsp_valid), 32'h1);
    check_output("fair_err_c6", 32'(rsp_err), 32'h1);
    check_output("fair_ops_cnt", 32'(ops_cnt), 32'd4);
    check_output("fair_err_cnt0", 32'(err_cnt), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("fair_rsp_c7", 32'(rsp_valid), 32'h0);
    check_output("fair_err_cnt1", 32'(err_cnt), 32'd1);
    check_output("fair_ops_cnt7", 32'(ops_cnt), 32'd4);

    // Order: min-first dequeue, then dequeue on empty
    do_reset();
    do_op(0, ENQ, 30, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(0, ENQ, 10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(0, ENQ, 20, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(2, DEQ, 0, 1'b0, 1'b1, 32'd10, 1'b0, 1'b1);
    do_op(2, DEQ, 0, 1'b0, 1'b1, 32'd20, 1'b0, 1'b1);
    do_op(2, DEQ, 0, 1'b0, 1'b1, 32'd30, 1'b0, 1'b1);
    do_op(2, DEQ, 0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Full: keys 7,9,11,13 fill the PQ; ENQ rejected; REPLACE still allowed
    do_reset();
    do_op(1, ENQ, 6,  1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(1, ENQ, 8,  1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(1, ENQ, 10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(1, ENQ, 12, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    do_op(1, ENQ, 98, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    do_op(3, REP, 2,  1'b1, 1'b1, 32'd7, 1'b0, 1'b1);

    // Busy: three busy cycles per op, no grant while busy
    do_reset();
    busy_len = 3;
    apply_stimulus(4'b0011, ENQ, 50);
    @(negedge clk);
    check_output("busy_gnt0", 32'(gnt), 32'h1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      apply_stimulus(4'b0010, ENQ, 50);
      @(negedge clk);
      check_output("busy_no_gnt", 32'(gnt), 32'h0);
      check_output("busy_no_rsp", 32'(rsp_valid), 32'h0);
    end
    next_cycle();
    @(negedge clk);
    check_output("busy_rsp0", 32'(rsp_valid), 32'h1);
    check_output("busy_gnt1", 32'(gnt), 32'h2);
    check_output("busy_kvi1", pq_kvi, 32'd51);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      apply_stimulus('0, ENQ, 0);
      @(negedge clk);
      check_output("busy_wait_rsp", 32'(rsp_valid), 32'h0);
    end
    next_cycle();
    @(negedge clk);
    check_output("busy_rsp1", 32'(rsp_valid), 32'h2);

    // Reset while pending: response dropped, pointer back to 0
    next_cycle();
    apply_stimulus(4'b0100, ENQ, 60);
    @(negedge clk);
    check_output("mid_gnt", 32'(gnt), 32'h4);
    next_cycle();
    apply_stimulus('0, ENQ, 0);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rsp_in_rst", 32'(rsp_valid), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("mid_no_rsp", 32'(rsp_valid), 32'h0);
      next_cycle();
    end
    apply_stimulus(4'b1111, ENQ, 70);
    @(negedge clk);
    check_output("mid_ptr0_gnt", 32'(gnt), 32'h1);
    next_cycle();
    apply_stimulus('0, ENQ, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
